// File: rtl/swin_pkg.sv
// Shared types and index-width helpers for the sliding-window write packer.
package swin_pkg;

   // At least one bit, so degenerate sizes (e.g. one lane) still give legal vectors.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PIX_PER_WORD = 64 / 8;
   localparam int LANE_IDX_W   = idx_w(PIX_PER_WORD);
   localparam int WORD_IDX_W   = idx_w(64);
   localparam int SLOT_IDX_W   = idx_w(8);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_FULL = 1'b1
   } state_t;

endpackage

// File: rtl/swin_slot_ring.sv
// Line-slot ring bookkeeping: write slot pointer, occupancy counter and
// sticky release-underflow flag.
module swin_slot_ring
   import swin_pkg::*;
#(
   parameter int NUM_LINES = 8
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             line_close,
   input  logic                             line_release,
   output logic [idx_w(NUM_LINES)-1:0]      slot_ptr,
   output logic [$clog2(NUM_LINES+1)-1:0]   lines_used,
   output logic                             fills,
   output logic                             underflow_err
);

   localparam int SLOT_W = idx_w(NUM_LINES);
   localparam int CNT_W  = $clog2(NUM_LINES + 1);

   logic rel_ok;

   // A release on an empty ring is ignored; it only raises the error flag.
   assign rel_ok = line_release && (lines_used != '0);
   assign fills  = line_close && !rel_ok && (lines_used == CNT_W'(NUM_LINES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_ptr      <= '0;
         lines_used    <= '0;
         underflow_err <= 1'b0;
      end else begin
         if (line_close)
            slot_ptr <= (slot_ptr == SLOT_W'(NUM_LINES - 1)) ? '0 : slot_ptr + 1'b1;
         if (line_close && !rel_ok)
            lines_used <= lines_used + 1'b1;
         else if (!line_close && rel_ok)
            lines_used <= lines_used - 1'b1;
         if (line_release && (lines_used == '0))
            underflow_err <= 1'b1;
      end
   end

endmodule

// File: rtl/swin_wr_packer.sv
// Write-side front end of the sliding-window line buffer: packs pixels into RAM words.
// Build option: SWIN_WR_ZERO_FILL_EN writes partial words full-width with unused lanes zeroed.
module swin_wr_packer
   import swin_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH    = 9,
   parameter int MEM_WORD_WIDTH    = 64,
   parameter int MEM_WR_MASK_WIDTH = 8,
   parameter int PIX_WIDTH         = 8,
   parameter int LINE_WORDS        = 64,
   parameter int NUM_LINES         = 8
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PIX_WIDTH-1:0]             pix_in,
   input  logic                             pix_valid,
   input  logic                             pix_last,
   output logic                             pix_ready,
   input  logic                             line_release,
   output logic [MEM_ADDR_WIDTH-1:0]        wr_addr,
   output logic [MEM_WORD_WIDTH-1:0]        wr_data,
   output logic [MEM_WR_MASK_WIDTH-1:0]     wr_data_mask,
   output logic                             wr_data_en,
   output logic                             line_done,
   output logic [$clog2(NUM_LINES+1)-1:0]   lines_used,
   output logic                             err
);

   localparam int PPW           = MEM_WORD_WIDTH / PIX_WIDTH;
   localparam int BYTES_PER_PIX = PIX_WIDTH / 8;
   localparam int LANE_W        = idx_w(PPW);
   localparam int WORD_W        = idx_w(LINE_WORDS);
   localparam int SLOT_W        = idx_w(NUM_LINES);

   logic [PIX_WIDTH-1:0]          lane_buf [PPW];
   logic [LANE_W-1:0]             lane_cnt;
   logic [WORD_W-1:0]             word_cnt;
   logic [SLOT_W-1:0]             slot_ptr;
   logic                          ring_fills;
   logic                          ring_err;
   logic                          trunc_err;
   state_t                        state_q;
   state_t                        state_d;
   logic                          pix_ready_q;

   logic                          accept;
   logic                          lane_full;
   logic                          last_word;
   logic                          vld_p0;
   logic                          close_p0;
   logic                          trunc_p0;
   logic [MEM_WORD_WIDTH-1:0]     word_p0;
   logic [MEM_WR_MASK_WIDTH-1:0]  mask_p0;
   logic [MEM_ADDR_WIDTH-1:0]     addr_p0;

   logic                          vld_p1;
   logic                          close_p1;
   logic [MEM_WORD_WIDTH-1:0]     word_p1;
   logic [MEM_WR_MASK_WIDTH-1:0]  mask_p1;
   logic [MEM_ADDR_WIDTH-1:0]     addr_p1;

   // ---- p0: accept, lane merge and flush/close decode
   assign accept    = pix_valid && pix_ready_q;
   assign lane_full = (lane_cnt == LANE_W'(PPW - 1));
   assign last_word = (word_cnt == WORD_W'(LINE_WORDS - 1));
   assign vld_p0    = accept && (lane_full || pix_last);
   assign close_p0  = accept && (pix_last || (lane_full && last_word));
   assign trunc_p0  = accept && lane_full && last_word && !pix_last;
   assign addr_p0   = MEM_ADDR_WIDTH'(slot_ptr) * MEM_ADDR_WIDTH'(LINE_WORDS)
                    + MEM_ADDR_WIDTH'(word_cnt);

   // The flushing pixel is merged combinationally so the write issues one cycle later.
   always_comb begin
      word_p0 = '0;
      for (int k = 0; k < PPW; k++) begin
         word_p0[k*PIX_WIDTH +: PIX_WIDTH] = lane_buf[k];
`ifdef SWIN_WR_ZERO_FILL_EN
         if (LANE_W'(k) > lane_cnt)
            word_p0[k*PIX_WIDTH +: PIX_WIDTH] = '0;
`endif
         if (LANE_W'(k) == lane_cnt)
            word_p0[k*PIX_WIDTH +: PIX_WIDTH] = pix_in;
      end
   end

   always_comb begin
      mask_p0 = '0;
      for (int b = 0; b < MEM_WR_MASK_WIDTH; b++) begin
`ifdef SWIN_WR_ZERO_FILL_EN
         mask_p0[b] = 1'b1;
`else
         mask_p0[b] = (LANE_W'(b / BYTES_PER_PIX) <= lane_cnt);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         lane_buf[lane_cnt] <= pix_in;
   end

   // ---- p1: write-port registers and packing counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         close_p1  <= 1'b0;
         word_p1   <= '0;
         mask_p1   <= '0;
         addr_p1   <= '0;
         lane_cnt  <= '0;
         word_cnt  <= '0;
         trunc_err <= 1'b0;
      end else begin
         vld_p1   <= vld_p0;
         close_p1 <= close_p0;
         if (vld_p0) begin
            word_p1 <= word_p0;
            mask_p1 <= mask_p0;
            addr_p1 <= addr_p0;
         end
         if (accept)
            lane_cnt <= vld_p0 ? '0 : lane_cnt + 1'b1;
         if (close_p0)
            word_cnt <= '0;
         else if (vld_p0)
            word_cnt <= word_cnt + 1'b1;
         if (trunc_p0)
            trunc_err <= 1'b1;
      end
   end

   swin_slot_ring #(
      .NUM_LINES     (NUM_LINES)
   ) u_ring (
      .clk           (clk),
      .rst           (rst),
      .line_close    (close_p0),
      .line_release  (line_release),
      .slot_ptr      (slot_ptr),
      .lines_used    (lines_used),
      .fills         (ring_fills),
      .underflow_err (ring_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         pix_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_ready_q <= (state_d == S_FILL);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (ring_fills)   state_d = S_FULL;
         S_FULL:  if (line_release) state_d = S_FILL;
         default: state_d = S_FILL;
      endcase
   end

   assign pix_ready    = pix_ready_q;
   assign wr_addr      = addr_p1;
   assign wr_data      = word_p1;
   assign wr_data_mask = mask_p1;
   assign wr_data_en   = vld_p1;
   assign line_done    = close_p1;
   assign err          = trunc_err || ring_err;

endmodule

// File: tb/tb_swin_wr_packer.sv
// Directed bench for swin_wr_packer: packing, partial words, ring back-pressure, auto-close, reset.
module tb_swin_wr_packer;

   localparam int AW = 9;
   localparam int DW = 64;
   localparam int MW = 8;
   localparam int PW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] pix_in;
   logic          pix_valid;
   logic          pix_last;
   logic          pix_ready;
   logic          line_release;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [MW-1:0] wr_data_mask;
   logic          wr_data_en;
   logic          line_done;
   logic [CW-1:0] lines_used;
   logic          err;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
      logic          done;
   } wr_t;

   wr_t wq[$];
   int  nvec = 0;
   int  nerr = 0;

   always #5 clk = ~clk;

   swin_wr_packer #(
      .MEM_ADDR_WIDTH    (AW),
      .MEM_WORD_WIDTH    (DW),
      .MEM_WR_MASK_WIDTH (MW),
      .PIX_WIDTH         (PW),
      .LINE_WORDS        (64),
      .NUM_LINES         (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_last     (pix_last),
      .pix_ready    (pix_ready),
      .line_release (line_release),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_data_mask (wr_data_mask),
      .wr_data_en   (wr_data_en),
      .line_done    (line_done),
      .lines_used   (lines_used),
      .err          (err)
   );

   // Capture every write strobe on the inactive edge.
   always @(negedge clk) begin
      if (!rst && wr_data_en)
         wq.push_back(wr_t'({wr_addr, wr_data, wr_data_mask, line_done}));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic wr_t wq_at(input int i);
      if (i < wq.size())
         return wq[i];
      return '0;
   endfunction

   task automatic idle();
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic send(input logic [7:0] p, input logic last);
      pix_valid = 1'b1;
      pix_in    = p;
      pix_last  = last;
      tick();
   endtask

   task automatic do_reset();
      idle();
      line_release = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      wq.delete();
   endtask

   initial begin
      rst = 1'b1;
      pix_in = '0;
      line_release = 1'b0;
      idle();
      tick();
      tick();
      chk("rst_ready", pix_ready, 0);
      chk("rst_en", wr_data_en, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_mask", wr_data_mask, 0);
      chk("rst_done", line_done, 0);
      chk("rst_used", lines_used, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      tick();
      chk("rst_ready_after", pix_ready, 1);

      // 16-pixel line, two full words
      for (int i = 0; i < 16; i++) begin
         send(8'(i), (i == 15));
         if (i == 6) chk("t1_lat_pre", wr_data_en, 0);
         if (i == 7) chk("t1_lat_w0", wr_data_en, 1);
      end
      idle();
      tick();
      chk("t1_nwr", wq.size(), 2);
      chk("t1_a0", wq_at(0).addr, 9'd0);
      chk("t1_d0", wq_at(0).data, 64'h0706050403020100);
      chk("t1_m0", wq_at(0).mask, 8'hFF);
      chk("t1_ld0", wq_at(0).done, 0);
      chk("t1_a1", wq_at(1).addr, 9'd1);
      chk("t1_d1", wq_at(1).data, 64'h0F0E0D0C0B0A0908);
      chk("t1_m1", wq_at(1).mask, 8'hFF);
      chk("t1_ld1", wq_at(1).done, 1);
      chk("t1_used", lines_used, 1);
      chk("t1_err", err, 0);

      // 3-pixel line, partial word
      do_reset();
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b1);
      idle();
      tick();
      chk("t2_nwr", wq.size(), 1);
      chk("t2_a", wq_at(0).addr, 9'd0);
      chk("t2_lo", wq_at(0).data[23:0], 24'hA3A2A1);
      chk("t2_ld", wq_at(0).done, 1);
`ifdef SWIN_WR_ZERO_FILL_EN
      chk("t2_m", wq_at(0).mask, 8'hFF);
      chk("t2_hi", wq_at(0).data[63:24], 40'h0);
`else
      chk("t2_m", wq_at(0).mask, 8'h07);
`endif

      // Fill all 8 slots, then release one
      do_reset();
      for (int i = 0; i < 64; i++)
         send(8'(i), ((i % 8) == 7));
      chk("t3_used", lines_used, 8);
      chk("t3_ready", pix_ready, 0);
      idle();
      tick();
      chk("t3_nwr", wq.size(), 8);
      for (int l = 0; l < 8; l++) begin
         chk($sformatf("t3_base%0d", l), wq_at(l).addr, 64'(l * 64));
         chk($sformatf("t3_ld%0d", l), wq_at(l).done, 1);
      end
      chk("t3_d7", wq_at(7).data, 64'h3F3E3D3C3B3A3938);
      pix_valid = 1'b1;
      pix_in    = 8'hEE;
      pix_last  = 1'b1;
      tick();
      tick();
      idle();
      tick();
      chk("t3_held_nwr", wq.size(), 8);
      chk("t3_held_used", lines_used, 8);
      line_release = 1'b1;
      tick();
      line_release = 1'b0;
      chk("t3_rel_ready", pix_ready, 1);
      chk("t3_rel_used", lines_used, 7);

      // Close coincident with release: no stall
      for (int i = 0; i < 7; i++)
         send(8'h60 + 8'(i), 1'b0);
      line_release = 1'b1;
      send(8'h67, 1'b1);
      line_release = 1'b0;
      chk("t5_used", lines_used, 7);
      chk("t5_ready", pix_ready, 1);
      idle();
      tick();
      chk("t5_ready2", pix_ready, 1);
      chk("t5_a", wq_at(8).addr, 9'd0);
      chk("t5_d", wq_at(8).data, 64'h6766656463626160);
      for (int i = 0; i < 8; i++)
         send(8'h70 + 8'(i), (i == 7));
      chk("t5_full_used", lines_used, 8);
      chk("t5_full_ready", pix_ready, 0);
      idle();
      tick();
      chk("t5_full_a", wq_at(9).addr, 9'd64);

      // 520 pixels without pix_last: auto-close after word 63
      do_reset();
      for (int i = 0; i < 520; i++) begin
         send(8'((i * 7 + 3) & 255), 1'b0);
         if (i == 510) chk("t4_err_pre", err, 0);
         if (i == 511) begin
            chk("t4_err", err, 1);
            chk("t4_used", lines_used, 1);
         end
      end
      idle();
      tick();
      chk("t4_nwr", wq.size(), 65);
      chk("t4_a0", wq_at(0).addr, 9'd0);
      chk("t4_d0", wq_at(0).data, 64'h342D261F18110A03);
      chk("t4_a63", wq_at(63).addr, 9'd63);
      chk("t4_d63", wq_at(63).data, 64'hFCF5EEE7E0D9D2CB);
      chk("t4_ld63", wq_at(63).done, 1);
      chk("t4_a64", wq_at(64).addr, 9'd64);
      chk("t4_lane0", wq_at(64).data[7:0], 8'h03);
      chk("t4_d64", wq_at(64).data, 64'h342D261F18110A03);
      chk("t4_ld64", wq_at(64).done, 0);
      chk("t4_used_end", lines_used, 1);

      // Reset mid-line discards the partial word
      do_reset();
      for (int i = 0; i < 5; i++)
         send(8'hC0 + 8'(i), 1'b0);
      idle();
      rst = 1'b1;
      #1;
      chk("t6_rst_en", wr_data_en, 0);
      chk("t6_rst_ready", pix_ready, 0);
      tick();
      tick();
      chk("t6_rst_en2", wr_data_en, 0);
      rst = 1'b0;
      tick();
      chk("t6_nwr_rst", wq.size(), 0);
      chk("t6_ready", pix_ready, 1);
      for (int i = 0; i < 8; i++)
         send(8'h10 + 8'(i), 1'b0);
      idle();
      tick();
      chk("t6_nwr", wq.size(), 1);
      chk("t6_a", wq_at(0).addr, 9'd0);
      chk("t6_d", wq_at(0).data, 64'h1716151413121110);
      chk("t6_ld", wq_at(0).done, 0);
      chk("t6_used", lines_used, 0);
      chk("t6_err_pre", err, 0);
      line_release = 1'b1;
      tick();
      line_release = 1'b0;
      chk("t6_err", err, 1);
      chk("t6_used_rel", lines_used, 0);
      tick();
      chk("t6_err_sticky", err, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
